// File: rtl/sum_result_fifo.sv
// Result FIFO that buffers sums from an upstream adder. The adder has no
// backpressure, so an input that arrives while the FIFO is full and nothing
// leaves in that cycle is dropped. A dropped input sets a sticky overflow
// flag and bumps a saturating drop counter. The head entry is read
// combinationally from registered storage.
module sum_result_fifo #(
  parameter int W     = 20,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [W-1:0]             in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [W-1:0]             out_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [7:0]               drop_cnt,
  input  logic                     clr_ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] rd_ptr_reg;
  logic [AW-1:0] wr_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          overflow_reg;
  logic [7:0]    drop_cnt_reg;

  logic [W-1:0]  mem [DEPTH];

  logic full;
  logic pop;
  logic push;
  logic drop;

  // A full FIFO still accepts an input when the head leaves in the same
  // cycle: the new entry takes the slot being freed.
  assign full = (count_reg == CW'(DEPTH));
  assign pop  = out_valid && out_ready;
  assign push = in_valid && (!full || pop);
  assign drop = in_valid && full && !pop;

  // Each storage entry is its own register so the whole array can be
  // cleared by reset and read combinationally at the head pointer.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : gen_mem
      logic         wr_en;
      logic [W-1:0] entry_reg;

      assign wr_en = push && (wr_ptr_reg == AW'(gi));

      // Capture the incoming sum when this slot is the write target.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          entry_reg <= '0;
        end else if (wr_en) begin
          entry_reg <= in_data;
        end
      end

      assign mem[gi] = entry_reg;
    end
  endgenerate

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
    end
  end

  // Occupancy: up on push only, down on pop only, held when both happen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else begin
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Drop bookkeeping; a drop in the same cycle as a clear wins, leaving
  // the flag set and the counter at one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_reg <= 1'b0;
      drop_cnt_reg <= 8'd0;
    end else if (drop) begin
      overflow_reg <= 1'b1;
      if (clr_ovf) begin
        drop_cnt_reg <= 8'd1;
      end else if (drop_cnt_reg != 8'hFF) begin
        drop_cnt_reg <= drop_cnt_reg + 8'd1;
      end
    end else if (clr_ovf) begin
      overflow_reg <= 1'b0;
      drop_cnt_reg <= 8'd0;
    end
  end

  assign out_valid = (count_reg != '0);
  assign out_data  = mem[rd_ptr_reg];
  assign count     = count_reg;
  assign overflow  = overflow_reg;
  assign drop_cnt  = drop_cnt_reg;

endmodule

// File: tb/tb_sum_result_fifo.sv
// Self-checking bench for sum_result_fifo. A queue-based reference model
// tracks the expected contents and drop bookkeeping; every cycle the DUT
// outputs are compared against it.
module tb_sum_result_fifo;

  localparam int W     = 20;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [CW-1:0] count;
  logic          overflow;
  logic [7:0]    drop_cnt;
  logic          clr_ovf;

  sum_result_fifo #(.W(W), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .count    (count),
    .overflow (overflow),
    .drop_cnt (drop_cnt),
    .clr_ovf  (clr_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [W-1:0] m_q[$];
  logic         m_ovf;
  int           m_drops;
  logic         m_zero_data;

  int n_checks;
  int n_fail;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_ovf       = 1'b0;
    m_drops     = 0;
    m_zero_data = 1'b1;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".out_valid"}, 32'(out_valid), 32'(m_q.size() != 0));
    check({tag, ".count"}, 32'(count), 32'(m_q.size()));
    check({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
    check({tag, ".drop_cnt"}, 32'(drop_cnt), 32'(m_drops));
    if (m_q.size() != 0) begin
      check({tag, ".out_data"}, 32'(out_data), 32'(m_q[0]));
    end else if (m_zero_data) begin
      check({tag, ".out_data_zero"}, 32'(out_data), 32'd0);
    end
  endtask

  // Advance one clock: update the model from the inputs as they stand at
  // the edge, then compare shortly after the edge.
  task automatic cycle(input string tag);
    bit do_pop;
    bit do_push;
    if (!rst_n) begin
      model_reset();
    end else begin
      do_pop  = out_ready && (m_q.size() != 0);
      do_push = in_valid && ((m_q.size() < DEPTH) || do_pop);
      if (do_pop) void'(m_q.pop_front());
      if (do_push) begin
        m_q.push_back(in_data);
        m_zero_data = 1'b0;
      end
      if (in_valid && !do_push) begin
        m_ovf = 1'b1;
        if (clr_ovf) m_drops = 1;
        else if (m_drops < 255) m_drops++;
      end else if (clr_ovf) begin
        m_ovf   = 1'b0;
        m_drops = 0;
      end
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic drive(input logic v, input logic [W-1:0] d, input logic r, input logic c);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    clr_ovf   = c;
  endtask

  initial begin
    logic [W-1:0] val;
    n_checks = 0;
    n_fail   = 0;
    model_reset();

    // Reset for 3 cycles, with an input offered that must be ignored
    rst_n = 1'b0;
    drive(1'b1, 20'hABCDE, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle("reset");
    drive(1'b0, '0, 1'b0, 1'b0);
    rst_n = 1'b1;
    cycle("post_reset");

    // Single entry in and out
    drive(1'b1, 20'h00123, 1'b0, 1'b0);
    cycle("single_push");
    drive(1'b0, '0, 1'b1, 1'b0);
    cycle("single_pop");
    drive(1'b0, '0, 1'b0, 1'b0);
    cycle("single_idle");

    // Fill with 1..4, drop 5, then drain
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, W'(i), 1'b0, 1'b0);
      cycle("fill");
    end
    drive(1'b1, 20'd5, 1'b0, 1'b0);
    cycle("drop5");
    drive(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cycle("drain");

    // Full pass-through: push 6 while popping at count 4
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, W'(i), 1'b0, 1'b0);
      cycle("refill");
    end
    drive(1'b1, 20'd6, 1'b1, 1'b0);
    cycle("pass_through");
    drive(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cycle("drain_pt");

    // Clear the sticky flag
    drive(1'b0, '0, 1'b0, 1'b1);
    cycle("clr_ovf");
    drive(1'b0, '0, 1'b0, 1'b0);
    cycle("after_clr");

    // Stream 12 results at 4-cycle spacing with the consumer always ready
    for (int i = 0; i < 12; i++) begin
      val = W'($urandom);
      drive(1'b1, val, 1'b1, 1'b0);
      cycle("stream_push");
      drive(1'b0, '0, 1'b1, 1'b0);
      for (int k = 0; k < 3; k++) cycle("stream_gap");
    end

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 2) == 0),
            1'($urandom_range(0, 15) == 0));
      cycle("random");
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cycle("random_drain");
    drive(1'b0, '0, 1'b0, 1'b1);
    cycle("random_clr");

    // Full FIFO, two drops, then clear colliding with a drop
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, W'($urandom), 1'b0, 1'b0);
      cycle("coll_fill");
    end
    drive(1'b1, 20'h0BEEF, 1'b0, 1'b0);
    cycle("coll_drop");
    cycle("coll_drop");
    drive(1'b1, 20'h0CAFE, 1'b0, 1'b1);
    cycle("coll_clr_drop");

    // Saturate the drop counter
    drive(1'b1, 20'h0DEAD, 1'b0, 1'b0);
    for (int i = 0; i < 260; i++) @(posedge clk);
    #1;
    m_drops = 255;
    m_ovf   = 1'b1;
    check_all("saturate");

    // Drain, then build count 3 and reset asynchronously mid-cycle
    drive(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cycle("pre_midrst");
    drive(1'b0, '0, 1'b0, 1'b1);
    cycle("pre_midrst_clr");
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, W'(i + 20'h00100), 1'b0, 1'b0);
      cycle("midrst_fill");
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("midrst_async");
    drive(1'b1, 20'h00777, 1'b0, 1'b0);
    cycle("midrst_held");
    drive(1'b0, '0, 1'b0, 1'b0);
    rst_n = 1'b1;
    cycle("midrst_release");
    drive(1'b1, 20'h00042, 1'b0, 1'b0);
    cycle("first_after_rst");
    drive(1'b0, '0, 1'b1, 1'b0);
    cycle("final_pop");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
